// File: rtl/phy_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : phy_init_ctrl
// Description : Walks a PHY register-write table through the MDIO write engine
//               after power-up, with per-write timeout and bounded retry.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_init_ctrl #(
    parameter int          NUM_CMDS     = 4,
    parameter int          IDX_W        = 4,
    parameter logic [4:0]  PHY_AD       = 5'h01,
    parameter logic [15:0] PWR_WAIT_CYC = 16'd1000,
    parameter logic [15:0] TIMEOUT_CYC  = 16'd128,
    parameter logic [3:0]  GAP_CYC      = 4'd2,
    parameter logic [1:0]  MAX_RETRY    = 2'd2
) (
    input  logic             i_mdc,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [4:0]       i_cmd_reg_ad,
    input  logic [15:0]      i_cmd_data,
    input  logic             i_write_done,
    output logic [IDX_W-1:0] o_cmd_idx,
    output logic             o_write_en,
    output logic [4:0]       o_phy_ad,
    output logic [4:0]       o_phyreg_ad,
    output logic [15:0]      o_phy_data,
    output logic             o_busy,
    output logic             o_init_done,
    output logic             o_init_err,
    output logic [1:0]       o_retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PWR_WAIT = 3'd1,
        S_LOAD     = 3'd2,
        S_WRITE    = 3'd3,
        S_GAP      = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CMDS - 1);
    localparam logic [15:0]      c_GAP_LAST = {12'd0, GAP_CYC} - 16'd1;
    localparam logic [15:0]      c_TO_LAST  = TIMEOUT_CYC - 16'd1;
    localparam logic [15:0]      c_PWR_LAST = PWR_WAIT_CYC - 16'd1;

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_retry;
    logic [15:0] w_timer_inc;

    // Saturating increment so a stuck state can never alias back to zero.
    assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;
    assign o_phy_ad    = PHY_AD;

    always_ff @(posedge i_mdc) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_timer     <= 16'd0;
            r_retry     <= 1'b0;
            o_cmd_idx   <= '0;
            o_write_en  <= 1'b0;
            o_phyreg_ad <= 5'd0;
            o_phy_data  <= 16'd0;
            o_busy      <= 1'b0;
            o_init_done <= 1'b0;
            o_init_err  <= 1'b0;
            o_retry_cnt <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        o_cmd_idx   <= '0;
                        o_retry_cnt <= 2'd0;
                        o_init_done <= 1'b0;
                        o_init_err  <= 1'b0;
                        o_busy      <= 1'b1;
                        r_timer     <= 16'd0;
                        r_retry     <= 1'b0;
                        r_state     <= (PWR_WAIT_CYC == 16'd0) ? S_LOAD : S_PWR_WAIT;
                    end
                end
                S_PWR_WAIT: begin
                    r_timer <= w_timer_inc;
                    if (r_timer == c_PWR_LAST) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    o_phyreg_ad <= i_cmd_reg_ad;
                    o_phy_data  <= i_cmd_data;
                    o_write_en  <= 1'b1;
                    r_timer     <= 16'd0;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_timer <= w_timer_inc;
                    // Done wins over a timeout landing on the same cycle.
                    if (i_write_done) begin
                        o_write_en  <= 1'b0;
                        o_retry_cnt <= 2'd0;
                        r_retry     <= 1'b0;
                        r_timer     <= 16'd0;
                        r_state     <= S_GAP;
                    end else if (r_timer == c_TO_LAST) begin
                        o_write_en <= 1'b0;
                        r_timer    <= 16'd0;
                        if (o_retry_cnt < MAX_RETRY) begin
                            o_retry_cnt <= o_retry_cnt + 2'd1;
                            r_retry     <= 1'b1;
                            r_state     <= S_GAP;
                        end else begin
                            o_init_err <= 1'b1;
                            o_busy     <= 1'b0;
                            r_state    <= S_ERR;
                        end
                    end
                end
                S_GAP: begin
                    r_timer <= w_timer_inc;
                    if (r_timer == c_GAP_LAST) begin
                        r_timer <= 16'd0;
                        if (r_retry) begin
                            r_retry <= 1'b0;
                            r_state <= S_LOAD;
                        end else if (o_cmd_idx == c_LAST_IDX) begin
                            o_init_done <= 1'b1;
                            o_busy      <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            o_cmd_idx <= o_cmd_idx + IDX_W'(1);
                            r_state   <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_init_ctrl.sv
`default_nettype none
// Randomized scoreboard bench for phy_init_ctrl: a command-level reference model
// predicts every write attempt and the final outcome; a monitor checks them.
module tb_phy_init_ctrl;

    localparam int          NCMD    = 3;
    localparam int          PWR     = 10;
    localparam int          TIMEOUT = 128;
    localparam int          MAXR    = 2;
    localparam int          K_WR    = 0;
    localparam int          K_DONE  = 1;
    localparam int          K_ERR   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_main, start_noise;
    logic        i_start;
    logic [4:0]  i_cmd_reg_ad;
    logic [15:0] i_cmd_data;
    logic        done_r;
    logic [3:0]  o_cmd_idx;
    logic        o_write_en;
    logic [4:0]  o_phy_ad;
    logic [4:0]  o_phyreg_ad;
    logic [15:0] o_phy_data;
    logic        o_busy, o_init_done, o_init_err;
    logic [1:0]  o_retry_cnt;

    logic [4:0]  tbl_reg  [16];
    logic [15:0] tbl_data [16];

    typedef struct {
        int          kind;
        int          idx;
        logic [4:0]  reg_ad;
        logic [15:0] data;
        int          retry;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   eng_q[$];
    int   dq[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    assign i_start      = start_main | start_noise;
    assign i_cmd_reg_ad = tbl_reg[o_cmd_idx];
    assign i_cmd_data   = tbl_data[o_cmd_idx];

    always #5 clk = ~clk;

    phy_init_ctrl #(
        .NUM_CMDS(NCMD), .IDX_W(4), .PHY_AD(5'h01), .PWR_WAIT_CYC(16'd10),
        .TIMEOUT_CYC(16'd128), .GAP_CYC(4'd2), .MAX_RETRY(2'd2)
    ) dut (
        .i_mdc(clk), .i_rst(rst), .i_start(i_start),
        .i_cmd_reg_ad(i_cmd_reg_ad), .i_cmd_data(i_cmd_data),
        .i_write_done(done_r), .o_cmd_idx(o_cmd_idx), .o_write_en(o_write_en),
        .o_phy_ad(o_phy_ad), .o_phyreg_ad(o_phyreg_ad), .o_phy_data(o_phy_data),
        .o_busy(o_busy), .o_init_done(o_init_done), .o_init_err(o_init_err),
        .o_retry_cnt(o_retry_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Done delay for one attempt: 0 = engine never answers, 1..TIMEOUT = success.
    function automatic int pick_delay();
        if (dq.size() != 0) return dq.pop_front();
        if ($urandom_range(0, 3) == 0) return 0;
        return int'($urandom_range(1, TIMEOUT));
    endfunction

    // Command-level model: one attempt per table entry unless it times out.
    task automatic plan_run();
        int   idx = 0;
        int   r   = 0;
        int   d;
        bit   fin = 1'b0;
        bit   ok;
        exp_t e;
        while (!fin) begin
            d  = pick_delay();
            ok = (d >= 1) && (d <= TIMEOUT);
            eng_q.push_back(d);
            e.kind = K_WR; e.idx = idx; e.reg_ad = tbl_reg[idx]; e.data = tbl_data[idx];
            e.retry = r; e.len = ok ? d : TIMEOUT;
            exp_q.push_back(e);
            if (ok) begin
                if (idx == NCMD - 1) begin
                    e.kind = K_DONE; exp_q.push_back(e); fin = 1'b1;
                end else begin
                    idx++; r = 0;
                end
            end else if (r < MAXR) begin
                r++;
            end else begin
                e.kind = K_ERR; exp_q.push_back(e); fin = 1'b1;
            end
        end
    endtask

    task automatic start_and_latency();
        int cnt = 1;
        @(negedge clk); start_main = 1'b1;
        @(negedge clk); start_main = 1'b0;
        chk("start_clears_done", 32'(o_init_done), 32'd0);
        chk("start_clears_err", 32'(o_init_err), 32'd0);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        while (!o_write_en && cnt < 400) begin
            @(negedge clk); cnt++;
        end
        chk("start_to_en_latency", 32'(cnt), 32'(PWR + 2));
    endtask

    task automatic do_run();
        int w = 0;
        plan_run();
        start_and_latency();
        while (!(o_init_done || o_init_err) && w < 5000) begin
            @(negedge clk); w++;
        end
        chk("run_finished_in_budget", 32'(w < 5000), 32'd1);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        eng_q.delete();
    endtask

    // Write-engine model: answers each attempt after its planned delay and
    // also throws spurious done pulses while enable is low.
    initial begin
        bit active = 1'b0;
        int cnt = 0;
        int cur_d = 0;
        done_r = 1'b0;
        forever begin
            @(negedge clk);
            done_r = 1'b0;
            if (rst) begin
                active = 1'b0;
            end else if (o_write_en) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    cur_d  = (eng_q.size() != 0) ? eng_q.pop_front() : 0;
                end
                cnt++;
                if (cur_d != 0 && cnt == cur_d) done_r = 1'b1;
            end else begin
                active = 1'b0;
                if ($urandom_range(0, 15) == 0) done_r = 1'b1;
            end
        end
    end

    // Start pulses while busy must be ignored.
    initial begin
        start_noise = 1'b0;
        forever begin
            @(negedge clk);
            start_noise = o_busy && !rst && ($urandom_range(0, 39) == 0);
        end
    end

    // Monitor: pops one expectation per enable rise / completion / error edge.
    initial begin
        bit   prev_en = 1'b0, prev_done = 1'b0, prev_err = 1'b0, have = 1'b0;
        int   len = 0;
        exp_t cur;
        exp_t o;
        forever begin
            @(negedge clk);
            if (o_write_en && !prev_en) begin
                len = 1;
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                    chk("wr_kind", 32'(K_WR), 32'(cur.kind));
                    chk("wr_idx", 32'(o_cmd_idx), 32'(cur.idx));
                    chk("wr_reg_ad", 32'(o_phyreg_ad), 32'(cur.reg_ad));
                    chk("wr_data", 32'(o_phy_data), 32'(cur.data));
                    chk("wr_retry_cnt", 32'(o_retry_cnt), 32'(cur.retry));
                    chk("wr_phy_ad", 32'(o_phy_ad), 32'h01);
                end
            end else if (o_write_en) begin
                len++;
            end else if (prev_en) begin
                if (have && !rst) chk("en_high_cycles", 32'(len), 32'(cur.len));
                have = 1'b0;
            end
            if ((o_init_done && !prev_done) || (o_init_err && !prev_err)) begin
                chk("outcome_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    o = exp_q.pop_front();
                    chk("outcome_kind", o_init_done ? 32'(K_DONE) : 32'(K_ERR), 32'(o.kind));
                    chk("outcome_idx", 32'(o_cmd_idx), 32'(o.idx));
                    chk("outcome_busy", 32'(o_busy), 32'd0);
                    chk("outcome_en", 32'(o_write_en), 32'd0);
                    chk("outcome_flags_exclusive", 32'(o_init_done & o_init_err), 32'd0);
                end
            end
            prev_en   = o_write_en;
            prev_done = o_init_done;
            prev_err  = o_init_err;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_main = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tbl_reg[i]  = 5'(i);
            tbl_data[i] = 16'(i * 16'h0101);
        end
        tbl_reg[0] = 5'h00; tbl_data[0] = 16'h3100;
        tbl_reg[1] = 5'h04; tbl_data[1] = 16'h01E1;
        tbl_reg[2] = 5'h10; tbl_data[2] = 16'h0060;

        repeat (3) @(negedge clk);
        chk("rst_en", 32'(o_write_en), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_flags", 32'({o_init_done, o_init_err}), 32'd0);
        chk("rst_idx_retry", 32'({o_cmd_idx, o_retry_cnt}), 32'd0);
        chk("rst_latched", 32'({o_phyreg_ad, o_phy_data}), 32'd0);
        chk("rst_phy_ad", 32'(o_phy_ad), 32'h01);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_stays_idle", 32'(o_busy), 32'd0);

        dq = '{66, 66, 66};          do_run();   // normal run
        dq = '{0, 66, 66, 66};       do_run();   // one timeout then success
        dq = '{66, 0, 0, 0};         do_run();   // retry exhaustion on idx 1
        dq = '{128, 1, 128};         do_run();   // done on the timeout cycle

        // Reset 30 cycles into the first write.
        dq = '{0};
        plan_run();
        start_and_latency();
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_en", 32'(o_write_en), 32'd0);
        chk("midrst_idx", 32'(o_cmd_idx), 32'd0);
        chk("midrst_flags", 32'({o_busy, o_init_done, o_init_err}), 32'd0);
        chk("midrst_retry", 32'(o_retry_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        eng_q.delete();
        dq.delete();

        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < 16; i++) begin
                tbl_reg[i]  = 5'($urandom);
                tbl_data[i] = 16'($urandom);
            end
            do_run();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phy_init_ctrl.md
Name: phy_init_ctrl

Overview:
- Sequences the MDIO register-write engine through a table of PHY register writes after power-up, one transaction at a time.
- Fetches each command from an external combinational table indexed by o_cmd_idx.
- Drives the write engine's enable, PHY address, register address and data. Waits for its done pulse, with timeout and bounded retry.
- Reports init complete or init error to the MAC/top-level sequencer.

Parameters:
- NUM_CMDS, 4: number of table entries written, valid range 1..2^IDX_W.
- IDX_W, 4: width of the command index.
- PHY_AD, 5'h01: PHY address driven on o_phy_ad for every command.
- PWR_WAIT_CYC, 16'd1000: i_mdc cycles to wait after i_start before the first write; 0 means no wait.
- TIMEOUT_CYC, 16'd128: cycles in WRITE without done before the attempt is abandoned. Must be greater than 70.
- GAP_CYC, 4'd2: cycles o_write_en is held low between transactions, minimum 1.
- MAX_RETRY, 2'd2: retries allowed per command before error.

Ports:
- i_mdc, input, 1: clock, the same MDC-divided clock as the write engine.
- i_rst, input, 1: synchronous, active-high reset.
- i_start, input, 1: start/restart pulse; accepted only in IDLE, DONE or ERR.
- i_cmd_reg_ad, input, 5: table register address at o_cmd_idx, combinational.
- i_cmd_data, input, 16: table data at o_cmd_idx, combinational.
- i_write_done, input, 1: one-cycle done pulse from the write engine.
- o_cmd_idx, output, IDX_W: current table index.
- o_write_en, output, 1: write engine enable; the engine runs while high and aborts to idle when low.
- o_phy_ad, output, 5: PHY address, equal to PHY_AD.
- o_phyreg_ad, output, 5: latched register address.
- o_phy_data, output, 16: latched write data.
- o_busy, output, 1: high in any state other than IDLE, DONE and ERR.
- o_init_done, output, 1: sticky completion flag.
- o_init_err, output, 1: sticky error flag.
- o_retry_cnt, output, 2: retries used on the current command.

Behaviour:
- All outputs are registered.
- Reset (sampled on the i_mdc rising edge) puts the FSM in IDLE and clears all outputs, index, timer and retry count to 0. o_phy_ad is constant PHY_AD.
- Reset mid-transaction: o_write_en is 0 after that edge, and the engine aborts to idle by its own rule.

States and transitions:
- IDLE: on i_start, go to PWR_WAIT, or to LOAD if PWR_WAIT_CYC==0. Clear index and retry count.
- PWR_WAIT: the timer counts 0..PWR_WAIT_CYC-1, then go to LOAD.
- LOAD, 1 cycle: latch i_cmd_reg_ad into o_phyreg_ad and i_cmd_data into o_phy_data. Clear the timer. Go to WRITE.
- WRITE: o_write_en=1 (registered, high from the first WRITE cycle). The timer increments each cycle.
  - If i_write_done==1, go to GAP and clear retry count. Done takes priority over a timeout in the same cycle.
  - Else if timer==TIMEOUT_CYC-1:
    - if o_retry_cnt<MAX_RETRY, increment o_retry_cnt and go to GAP with a retry flag set;
    - otherwise go to ERR.
- GAP: o_write_en=0 for GAP_CYC cycles. Then:
  - retry flag set: back to LOAD with the same index;
  - else if o_cmd_idx==NUM_CMDS-1: go to DONE;
  - else: increment o_cmd_idx and go to LOAD.
- DONE: o_init_done=1, o_busy=0, o_write_en=0. i_start clears o_init_done and restarts as from IDLE.
- ERR: o_init_err=1, o_write_en=0. o_cmd_idx holds the failing index. i_start clears o_init_err and restarts.

Boundary rules:
- i_write_done outside WRITE is ignored.
- i_start while o_busy=1 is ignored.
- The index never wraps. NUM_CMDS==1 goes LOAD, WRITE, GAP, DONE.
- The timer is 16 bits and saturates; it never wraps.
- o_write_en always falls the cycle after done is sampled, so the engine cannot start an unrequested second frame.

Latency:
- From i_start to the first o_write_en: PWR_WAIT_CYC+2 cycles.
- One transaction with the engine model: WRITE lasts until done (about 66 cycles), then GAP_CYC cycles.

Test Plan:
- Normal run: NUM_CMDS=3, PWR_WAIT_CYC=10, engine model gives done 66 cycles after en rises; table {0x00:0x3100, 0x04:0x01E1, 0x10:0x0060} -> three en pulses, o_phyreg_ad/o_phy_data match per index, o_init_done=1 after the last GAP, o_init_err=0.
- Single timeout then success: first attempt gives no done -> en falls after 128 cycles, o_retry_cnt=1, LOAD repeats idx 0, second attempt done -> retry count 0, sequence completes.
- Retry exhaustion with MAX_RETRY=2: idx 1 never gets done -> three en attempts, then o_init_err=1, o_cmd_idx=1, o_busy=0, o_write_en=0.
- Reset mid-WRITE: assert i_rst at cycle 30 of idx 0 -> next edge o_write_en=0, idx=0, all flags 0; new i_start reruns from PWR_WAIT.
- Start handling: i_start pulses during WRITE are ignored (index unchanged); i_start in DONE clears o_init_done and rewrites all entries.
- Spurious done: pulse i_write_done in PWR_WAIT and GAP -> no state or index change; done coincident with the timeout cycle -> treated as success.
